// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants and command format for the PWM fade scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int DUTY_W     = 8;
    localparam int FRAME_LEN  = 256;
    localparam int FRAME_W    = $clog2(FRAME_LEN);
    localparam int CMD_CH_W   = 8;
    localparam int CMD_RATE_W = 16;

    typedef struct packed {
        logic [CMD_CH_W-1:0]   ch;
        logic [DUTY_W-1:0]     target;
        logic [CMD_RATE_W-1:0] rate;
    } fade_cmd_t;

endpackage

`default_nettype wire

// File: rtl/fade_channel.sv
// ============================================================================
// Module      : fade_channel
// Description : One fade channel: duty/target/rate registers and step logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fade_channel
    import pwm_pkg::*;
#(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tick,
    input  logic              i_hold,
    input  logic              i_wr_en,
    input  logic [DUTY_W-1:0] i_target,
    input  logic [RATE_W-1:0] i_rate,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_busy
);

    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_target;
    logic [RATE_W-1:0] r_rate;
    logic [RATE_W-1:0] r_rate_cnt;
    logic              w_ramping;
    logic              w_step_en;

    assign w_ramping = (r_duty != r_target);
    assign w_step_en = i_tick & ~i_hold & w_ramping;

    // A write on a tick cycle takes priority and suppresses this tick's step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty     <= '0;
            r_target   <= '0;
            r_rate     <= '0;
            r_rate_cnt <= '0;
        end else if (i_wr_en) begin
            r_target   <= i_target;
            r_rate     <= i_rate;
            r_rate_cnt <= i_rate;
        end else if (w_step_en) begin
            if (r_rate_cnt == '0) begin
                r_duty     <= (r_duty < r_target) ? r_duty + 1'b1 : r_duty - 1'b1;
                r_rate_cnt <= r_rate;
            end else begin
                r_rate_cnt <= r_rate_cnt - 1'b1;
            end
        end
    end

    assign o_duty = r_duty;
    assign o_busy = w_ramping;

endmodule

`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
// ============================================================================
// Module      : pwm_fade_ctrl
// Description : Multi-channel fade scheduler feeding 8-bit PWM duty inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int RATE_W = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [CH_W-1:0]          cmd_ch_i,
    input  logic [DUTY_W-1:0]        cmd_target_i,
    input  logic [RATE_W-1:0]        cmd_rate_i,
    input  logic                     hold_i,
    output logic [NUM_CH*DUTY_W-1:0] duty_o,
    output logic [NUM_CH-1:0]        busy_o,
    output logic                     frame_tick_o
);

    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_ready;
    logic               w_tick;
    logic               w_accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_frame_cnt <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_ready     <= 1'b1;
        end
    end

    assign w_tick       = (r_frame_cnt == FRAME_W'(FRAME_LEN - 1));
    assign w_accept     = cmd_valid_i & r_ready;
    assign cmd_ready_o  = r_ready;
    assign frame_tick_o = w_tick;

    // Out-of-range channel indices match no instance and are silently dropped.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic w_wr_en;

        assign w_wr_en = w_accept & (cmd_ch_i == CH_W'(k));

        fade_channel #(
            .RATE_W (RATE_W)
        ) u_fade_channel (
            .clk      (clk_i),
            .rst      (rst_i),
            .i_tick   (w_tick),
            .i_hold   (hold_i),
            .i_wr_en  (w_wr_en),
            .i_target (cmd_target_i),
            .i_rate   (cmd_rate_i),
            .o_duty   (duty_o[k*DUTY_W +: DUTY_W]),
            .o_busy   (busy_o[k])
        );
    end

endmodule

`default_nettype wire
